// File: rtl/trigger_pkg.sv
// Shared types and constants for the acquisition trigger engine.
// State encoding and trigger mode values.
package trigger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_A,
    WAIT_B,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [1:0] MODE_RISE  = 2'd0;
  localparam logic [1:0] MODE_FALL  = 2'd1;
  localparam logic [1:0] MODE_FORCE = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'd3;

endpackage

// File: rtl/trigger_if.sv
// Sample stream in, FIFO write port out.
// slave is the engine side, master the environment side.
interface trigger_if #(
  parameter int NCH = 14,
  parameter int W   = 12
);
  logic             in_valid;
  logic [NCH*W-1:0] in_data;
  logic             fifo_wr;
  logic [NCH*W-1:0] fifo_data;
  logic             fifo_afull;

  modport master (
    output in_valid, in_data, fifo_afull,
    input  fifo_wr, fifo_data
  );

  modport slave (
    input  in_valid, in_data, fifo_afull,
    output fifo_wr, fifo_data
  );
endinterface

// File: rtl/trig_compare.sv
// Picks the trigger channel out of the stage-1 word and
// compares it against both thresholds (signed, strict).
module trig_compare #(
  parameter int NCH = 14,
  parameter int W   = 12,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH*W-1:0]    data,
  input  logic [CW-1:0]       chan,
  input  logic signed [W-1:0] lower,
  input  logic signed [W-1:0] upper,
  output logic                below,
  output logic                above
);
  logic signed [W-1:0] sample;

  assign sample = data[int'(chan)*W +: W];
  assign below  = sample < lower;
  assign above  = sample > upper;
endmodule

// File: rtl/trigger_engine.sv
// Threshold-crossing trigger and capture engine feeding the
// sample FIFO; FSM, counters and output registers.
module trigger_engine
  import trigger_pkg::*;
#(
  parameter int NCH   = 14,
  parameter int W     = 12,
  parameter int LEN_W = 16,
  parameter int TO_W  = 16,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  trigger_if.slave         bus,
  input  logic             arm,
  input  logic             abort,
  input  logic [CW-1:0]    cfg_chan,
  input  logic [1:0]       cfg_mode,
  input  logic [W-1:0]     cfg_lower,
  input  logic [W-1:0]     cfg_upper,
  input  logic [LEN_W-1:0] cfg_length,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count,
  output logic             timed_out,
  output logic             overflow
);
  state_t             state;
  logic               s1_valid;
  logic [NCH*W-1:0]   s1_data;
  logic [CW-1:0]      chan_l;
  logic [1:0]         mode_l;
  logic [W-1:0]       lower_l;
  logic [W-1:0]       upper_l;
  logic [LEN_W-1:0]   length_l;
  logic [TO_W-1:0]    timeout_l;
  logic [TO_W-1:0]    to_cnt;
  logic below, above;
  logic arm_ok, fire, hit_to;
  logic waiting, trig, cap;

  trig_compare #(.NCH(NCH), .W(W)) u_cmp (
    .data  (s1_data),
    .chan  (chan_l),
    .lower (lower_l),
    .upper (upper_l),
    .below (below),
    .above (above)
  );

  always_comb begin
    arm_ok = below;
    fire   = above;
    unique case (1'b1)
      mode_l == MODE_FALL: begin
        arm_ok = above;
        fire   = below;
      end
      mode_l == MODE_FORCE: begin
        arm_ok = 1'b0;
        fire   = 1'b1;
      end
      default: ;
    endcase
    hit_to  = (mode_l == MODE_AUTO) &&
              (to_cnt == timeout_l);
    waiting = (state == WAIT_A) ||
              (state == WAIT_B);
    trig    = waiting &&
              (hit_to || (state == WAIT_B && fire));
    // The triggering beat is itself the first capture beat
    cap     = s1_valid && (trig || state == CAPTURE);
  end

  assign busy = state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      chan_l        <= '0;
      mode_l        <= '0;
      lower_l       <= '0;
      upper_l       <= '0;
      length_l      <= '0;
      timeout_l     <= '0;
      to_cnt        <= '0;
      bus.fifo_wr   <= 1'b0;
      bus.fifo_data <= '0;
      done          <= 1'b0;
      count         <= '0;
      timed_out     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      s1_valid    <= bus.in_valid;
      s1_data     <= bus.in_data;
      bus.fifo_wr <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else if (cap) begin
        if (state != CAPTURE) timed_out <= hit_to;
        if (bus.fifo_afull) begin
          overflow <= 1'b1;
          state    <= DONE;
        end else begin
          bus.fifo_wr   <= 1'b1;
          bus.fifo_data <= s1_data;
          count         <= count + 1'b1;
          state <= (count + 1'b1 == length_l) ?
                   DONE : CAPTURE;
        end
      end else begin
        unique case (state)
          IDLE: if (arm) begin
            chan_l    <= cfg_chan;
            mode_l    <= cfg_mode;
            lower_l   <= cfg_lower;
            upper_l   <= cfg_upper;
            length_l  <= cfg_length;
            timeout_l <= cfg_timeout;
            count     <= '0;
            timed_out <= 1'b0;
            overflow  <= 1'b0;
            to_cnt    <= '0;
            if (cfg_length == '0)
              state <= DONE;
            else if (cfg_mode == MODE_FORCE)
              state <= WAIT_B;
            else
              state <= WAIT_A;
          end
          WAIT_A, WAIT_B: if (s1_valid) begin
            if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
            if (state == WAIT_A && arm_ok)
              state <= WAIT_B;
          end
          CAPTURE: ;
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_trigger_engine.sv
// Randomised + directed bench for trigger_engine with a
// beat-level reference model and a write scoreboard.
`timescale 1ns/1ps
module tb_trigger_engine;
  import trigger_pkg::*;

  localparam int NCH   = 14;
  localparam int W     = 12;
  localparam int LEN_W = 16;
  localparam int TO_W  = 16;
  localparam int DW    = NCH * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic [3:0]       cfg_chan = '0;
  logic [1:0]       cfg_mode = '0;
  logic [W-1:0]     cfg_lower = '0;
  logic [W-1:0]     cfg_upper = '0;
  logic [LEN_W-1:0] cfg_length = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic busy, done, timed_out, overflow;
  logic [LEN_W-1:0] count;

  trigger_if #(.NCH(NCH), .W(W)) bus ();

  trigger_engine #(
    .NCH(NCH), .W(W), .LEN_W(LEN_W), .TO_W(TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .arm         (arm),
    .abort       (abort),
    .cfg_chan    (cfg_chan),
    .cfg_mode    (cfg_mode),
    .cfg_lower   (cfg_lower),
    .cfg_upper   (cfg_upper),
    .cfg_length  (cfg_length),
    .cfg_timeout (cfg_timeout),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .timed_out   (timed_out),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] bdata[$];
  bit            bvalid[$];

  int  nchk = 0;
  int  nfail = 0;
  int  e_count, e_fch, e_fval;
  bit  e_to, e_ovf, e_done, e_hasf;
  bit  chk_lat = 0;
  int  afull_lim = 0;
  int  end_kind = 0;
  int  end_req = 0, end_ack = 0;
  int  busy_req = 0, busy_ack = 0;
  int  done_cnt = 0, wr_seen = 0;
  bit  got_first = 0, prev_wr = 0;
  logic [DW-1:0] first_word = '0;

  function automatic void chk(string nm, longint act,
                              longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endfunction

  function automatic void chk_w(string nm,
                                logic [DW-1:0] act,
                                logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  // Monitor: scoreboard pops on every FIFO write
  always @(negedge clk) begin
    logic [DW-1:0]       w;
    logic signed [W-1:0] fs;
    if (arm) begin
      done_cnt   = 0;
      wr_seen    = 0;
      got_first  = 0;
      first_word = '0;
    end
    if (bus.fifo_wr) begin
      if (!got_first) begin
        first_word = bus.fifo_data;
        got_first  = 1;
      end
      wr_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        w = exp_q.pop_front();
        chk_w("fifo_data", bus.fifo_data, w);
      end
    end
    if (done) begin
      done_cnt++;
      if (chk_lat) chk("done_after_wr", prev_wr, 1);
    end
    prev_wr = bus.fifo_wr;
    bus.fifo_afull = (afull_lim != 0) &&
                     (wr_seen >= afull_lim);
    if (busy_req != busy_ack) begin
      chk("arm_to_busy", busy, 1);
      busy_ack = busy_req;
    end
    if (end_req != end_ack) begin
      if (end_kind == 0) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fifo_wr", bus.fifo_wr, 0);
        chk_w("rst_fifo_data", bus.fifo_data, '0);
      end else begin
        chk("count", count, e_count);
        chk("timed_out", timed_out, e_to);
        chk("overflow", overflow, e_ovf);
        chk("done_pulses", done_cnt, e_done);
        chk("idle", busy, 0);
        if (e_hasf) begin
          fs = first_word[e_fch*W +: W];
          chk("first_word", fs, e_fval);
        end
      end
      chk("pending_writes", exp_q.size(), 0);
      end_ack = end_req;
    end
  end

  function automatic logic [DW-1:0] mkword(int ch, int v,
                                           int idx);
    logic [DW-1:0] wd;
    int r;
    for (int c = 0; c < NCH; c++) begin
      r = int'($urandom_range(0, 80)) - 40;
      wd[c*W +: W] = r[W-1:0];
    end
    if (idx >= 0) wd[0 +: W] = idx[W-1:0];
    if (ch >= 0) wd[ch*W +: W] = v[W-1:0];
    return wd;
  endfunction

  task automatic add_beat(bit v, logic [DW-1:0] wd);
    bvalid.push_back(v);
    bdata.push_back(wd);
  endtask

  // Reference: walk valid beats, no cycle timing involved
  task automatic run_model(int mode, int chan, int lower,
                           int upper, int len, int tmo,
                           int alim);
    bit seen, trig;
    int n, beats, s;
    logic signed [W-1:0] smp;
    e_count = 0;
    e_to    = 0;
    e_ovf   = 0;
    e_done  = (len == 0);
    seen  = (mode == int'(MODE_FORCE));
    trig  = 0;
    beats = 0;
    n     = 0;
    for (int i = 0; i < bdata.size(); i++) begin
      if (bvalid[i] && !e_done) begin
        smp = bdata[i][chan*W +: W];
        s = smp;
        if (!trig) begin
          if (mode == int'(MODE_AUTO) && beats == tmo) begin
            trig = 1;
            e_to = 1;
          end else if (!seen) begin
            seen = (mode == int'(MODE_FALL)) ?
                   (s > upper) : (s < lower);
          end else begin
            trig = (mode == int'(MODE_FORCE)) ||
                   ((mode == int'(MODE_FALL)) ?
                    (s < lower) : (s > upper));
          end
          beats++;
        end
        if (trig) begin
          if (alim != 0 && n == alim) begin
            e_ovf  = 1;
            e_done = 1;
          end else begin
            exp_q.push_back(bdata[i]);
            n++;
            if (n == len) e_done = 1;
          end
        end
      end
    end
    e_count = n;
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 10 && end_ack != end_req; k++) begin
      @(negedge clk);
      #1;
    end
    if (end_ack != end_req) begin
      $display("FAIL monitor_ack: got %0d expected %0d",
               end_ack, end_req);
      $fatal(1);
    end
  endtask

  task automatic run_test(int mode, int chan, int lower,
                          int upper, int len, int tmo,
                          int alim, int fch, int fval,
                          bit hasf, bit use_rst);
    run_model(mode, chan, lower, upper, len, tmo, alim);
    afull_lim = alim;
    chk_lat = e_done && !e_ovf && len > 0;
    e_hasf = hasf;
    e_fch  = fch;
    e_fval = fval;
    cfg_chan    = chan[3:0];
    cfg_mode    = mode[1:0];
    cfg_lower   = lower[W-1:0];
    cfg_upper   = upper[W-1:0];
    cfg_length  = len[LEN_W-1:0];
    cfg_timeout = tmo[TO_W-1:0];
    @(posedge clk); #1;
    arm = 1;
    bus.in_valid = 0;
    @(posedge clk); #1;
    arm = 0;
    busy_req++;
    cfg_chan    = 4'($urandom_range(0, 13));
    cfg_mode    = 2'($urandom_range(0, 3));
    cfg_lower   = W'($urandom);
    cfg_upper   = W'($urandom);
    cfg_length  = LEN_W'($urandom_range(0, 3));
    cfg_timeout = TO_W'($urandom_range(0, 3));
    for (int i = 0; i < bdata.size(); i++) begin
      bus.in_valid = bvalid[i];
      bus.in_data  = bdata[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    bus.in_data  = mkword(-1, 0, -1);
    if (use_rst) begin
      rst = 1;
      #1;
      end_kind = 0;
      end_req++;
      wait_ack();
      @(posedge clk); #1;
      rst = 0;
    end else begin
      if (!e_done) begin
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
      end
      for (int k = 0; k < 60 && busy; k++) begin
        @(posedge clk); #1;
      end
      repeat (2) begin
        @(posedge clk); #1;
      end
      end_kind = 1;
      end_req++;
      wait_ack();
    end
    bdata.delete();
    bvalid.delete();
    afull_lim = 0;
    chk_lat = 0;
  endtask

  initial begin
    int md, ch, lo, up;
    bus.in_valid = 0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    end_kind = 0;
    end_req++;
    wait_ack();
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      add_beat(1, mkword(3, -20 + 5*i, i + 1));
    run_test(int'(MODE_RISE), 3, -10, 10, 4, 0, 0,
             3, 15, 1, 0);

    for (int i = 0; i < 13; i++)
      add_beat(1, mkword(3, 20 - 5*i, i + 1));
    run_test(int'(MODE_FALL), 3, -10, 10, 4, 0, 0,
             3, -15, 1, 0);

    for (int i = 0; i < 12; i++)
      add_beat(1, mkword(3, 0, i + 1));
    run_test(int'(MODE_AUTO), 3, -10, 10, 4, 5, 0,
             0, 6, 1, 0);

    for (int i = 0; i < 10; i++)
      add_beat(i % 2 == 0, mkword(3, 0, i + 1));
    run_test(int'(MODE_FORCE), 3, -10, 10, 3, 0, 0,
             0, 1, 1, 0);

    for (int i = 0; i < 12; i++)
      add_beat(1, mkword(3, 0, i + 1));
    run_test(int'(MODE_FORCE), 3, -10, 10, 8, 0, 2,
             0, 1, 1, 0);

    add_beat(1, mkword(3, 0, 1));
    for (int i = 0; i < 4; i++)
      add_beat(0, mkword(3, 0, i + 2));
    run_test(int'(MODE_FORCE), 3, -10, 10, 5, 0, 0,
             0, 1, 1, 0);

    cfg_mode   = MODE_FORCE;
    cfg_length = 4;
    @(posedge clk); #1;
    arm   = 1;
    abort = 1;
    @(posedge clk); #1;
    arm   = 0;
    abort = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1;
      bus.in_data  = mkword(-1, 0, -1);
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    e_done = 0;
    e_hasf = 0;
    end_kind = 1;
    end_req++;
    wait_ack();

    for (int i = 0; i < 4; i++)
      add_beat(1, mkword(3, 0, i + 1));
    run_test(int'(MODE_RISE), 3, -10, 10, 0, 0, 0,
             0, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      md = $urandom_range(0, 3);
      ch = $urandom_range(0, NCH - 1);
      lo = int'($urandom_range(0, 40)) - 30;
      up = int'($urandom_range(0, 40)) - 10;
      for (int i = 0; i < 30; i++)
        add_beat($urandom_range(0, 3) != 0,
                 mkword(-1, 0, -1));
      run_test(md, ch, lo, up, $urandom_range(1, 10),
               $urandom_range(0, 25), 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 6; i++)
      add_beat(i < 3, mkword(3, 0, i + 1));
    run_test(int'(MODE_FORCE), 3, -10, 10, 10, 0, 0,
             0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
